asym_fifoctl_s1_df: RTL and testbench

//  Single-clock asymmetric FIFO RAM controller for an external dual-port RAM, max(in,out) bits wide.

---
 rtl/asym_fifoctl_s1_df.sv | 248 ++++++++++++++++++++++++
 tb/tb_asym_fifoctl_s1_df.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/asym_fifoctl_s1_df.sv
`default_nettype none
// ============================================================================
//  Module   : asym_fifoctl_s1_df
//  Purpose  : Single-clock asymmetric FIFO controller for an external
//             dual-port RAM (synchronous write, asynchronous read) that is
//             max(data_in_width, data_out_width) bits wide. Packs pushed
//             sub-words into RAM words (upsize), unpacks RAM words into
//             popped sub-words (downsize), or passes through (equal widths).
//             Provides runtime almost-empty/almost-full thresholds, a RAM
//             word count and split overflow/underflow error reporting.
//  Ports    : clk, rst_n (async, active low)
//             push_req_n, flush_n, pop_req_n  producer/consumer requests
//             data_in, data_out                 producer/consumer data
//             we_n, wr_addr, rd_addr, wr_data, rd_data   RAM interface
//             ae_level, af_level                threshold inputs
//             word_count, empty, almost_empty, half_full, almost_full,
//             full, ram_full, part_wd, error[1:0] status outputs
//  Revision : 1.0  initial release
// ============================================================================
module asym_fifoctl_s1_df #(
    parameter  int data_in_width  = 8,
    parameter  int data_out_width = 32,
    parameter  int depth          = 16,
    parameter  int err_mode       = 0,
    parameter  int byte_order     = 0,
    localparam int AW     = $clog2(depth + 1),
    // Equals AW-1 for power-of-two depths and still covers every word
    // when depth is not a power of two.
    localparam int ADDR_W = $clog2(depth),
    localparam int MAXW   = (data_in_width > data_out_width) ? data_in_width : data_out_width
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_req_n,
    input  logic                      flush_n,
    input  logic                      pop_req_n,
    input  logic [data_in_width-1:0]  data_in,
    input  logic [MAXW-1:0]           rd_data,
    input  logic [AW-1:0]             ae_level,
    input  logic [AW-1:0]             af_level,
    output logic                      we_n,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [ADDR_W-1:0]         rd_addr,
    output logic [MAXW-1:0]           wr_data,
    output logic [data_out_width-1:0] data_out,
    output logic [AW-1:0]             word_count,
    output logic                      empty,
    output logic                      almost_empty,
    output logic                      half_full,
    output logic                      almost_full,
    output logic                      full,
    output logic                      ram_full,
    output logic                      part_wd,
    output logic [1:0]                error
);

    localparam int MINW = (data_in_width > data_out_width) ? data_out_width : data_in_width;
    localparam int K    = MAXW / MINW;
    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(depth - 1);
    localparam logic [AW-1:0]     C_DEPTH     = AW'(depth);
    localparam logic [AW-1:0]     C_HALF      = AW'((depth + 1) / 2);

    // ------------------------------------------------------------------
    // Core RAM bookkeeping
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     count_q,  count_d;
    logic [1:0]        error_q,  error_d;

    logic w_push, w_pop;
    logic w_int_push, w_int_pop;
    logic w_ram_push, w_ram_pop;
    logic w_ram_full, w_ram_empty;
    logic w_ovf, w_udf;

    // Requests are gated by reset so nothing reaches the RAM while rst_n is low.
    assign w_push      = ~push_req_n & rst_n;
    assign w_pop       = ~pop_req_n  & rst_n;
    assign w_ram_full  = (count_q == C_DEPTH);
    assign w_ram_empty = (count_q == '0);

    // A simultaneous pop frees the slot a push into a full RAM needs.
    assign w_ram_push  = w_int_push & (~w_ram_full | w_int_pop);
    assign w_ram_pop   = w_int_pop & ~w_ram_empty;
    assign w_ovf       = w_int_push & ~w_ram_push;
    assign w_udf       = w_pop & w_ram_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_ram_push) begin
            wr_ptr_d = (wr_ptr_q == C_LAST_ADDR) ? '0 : wr_ptr_q + ADDR_W'(1);
        end
        if (w_ram_pop) begin
            rd_ptr_d = (rd_ptr_q == C_LAST_ADDR) ? '0 : rd_ptr_q + ADDR_W'(1);
        end
        case ({w_ram_push, w_ram_pop})
            2'b10:   count_d = count_q + AW'(1);
            2'b01:   count_d = count_q - AW'(1);
            default: count_d = count_q;
        endcase
        if (err_mode == 0) begin
            error_d = error_q | {w_udf, w_ovf};
        end else begin
            error_d = {w_udf, w_ovf};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    assign we_n         = ~w_ram_push;
    assign wr_addr      = wr_ptr_q;
    assign rd_addr      = rd_ptr_q;
    assign word_count   = count_q;
    assign error        = error_q;
    assign ram_full     = w_ram_full;
    assign empty        = w_ram_empty;
    assign almost_empty = (count_q <= ae_level);
    assign half_full    = (count_q >= C_HALF);
    // count >= depth - af_level, evaluated as count + af_level >= depth so the
    // threshold saturates at zero instead of wrapping.
    assign almost_full  = ({1'b0, count_q} + {1'b0, af_level}) >= {1'b0, C_DEPTH};

    // ------------------------------------------------------------------
    // Width adaptation
    // ------------------------------------------------------------------
    generate
        if (data_in_width < data_out_width) begin : g_upsize
            localparam int CW = $clog2(K);
            logic [CW-1:0]   wd_cntr_q, wd_cntr_d;
            logic [MAXW-1:0] acc_q, acc_d;
            logic [MAXW-1:0] w_din_cur, w_din_first;
            logic            w_last, w_part, w_flush, w_complete;
            int              w_sh_cur, w_sh_first;

            // Sub-word slot i sits at the MSB end for byte_order 0.
            assign w_sh_cur    = (byte_order == 0) ? (K - 1 - int'(wd_cntr_q)) * data_in_width
                                                   : int'(wd_cntr_q) * data_in_width;
            assign w_sh_first  = (byte_order == 0) ? (K - 1) * data_in_width : 0;
            assign w_din_cur   = MAXW'(data_in) << w_sh_cur;
            assign w_din_first = MAXW'(data_in) << w_sh_first;

            assign w_last     = (wd_cntr_q == CW'(K - 1));
            assign w_part     = (wd_cntr_q != '0);
            assign w_flush    = ~flush_n & w_part & rst_n;
            // A flush takes priority; a push in the same cycle opens the next word.
            assign w_complete = w_push & w_last & ~w_flush;

            assign w_int_push = w_complete | w_flush;
            assign w_int_pop  = w_pop & ~w_ram_empty;
            assign wr_data    = w_flush ? acc_q : (acc_q | w_din_cur);
            assign data_out   = rd_data;
            assign full       = w_ram_full & w_last;
            assign part_wd    = w_part;

            always_comb begin
                wd_cntr_d = wd_cntr_q;
                acc_d     = acc_q;
                // A dropped (overflowing) write leaves the partial word untouched.
                if (!w_ovf) begin
                    if (w_flush) begin
                        acc_d     = w_push ? w_din_first : '0;
                        wd_cntr_d = w_push ? CW'(1) : '0;
                    end else if (w_push) begin
                        if (w_last) begin
                            acc_d     = '0;
                            wd_cntr_d = '0;
                        end else begin
                            acc_d     = acc_q | w_din_cur;
                            wd_cntr_d = wd_cntr_q + CW'(1);
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wd_cntr_q <= '0;
                    acc_q     <= '0;
                end else begin
                    wd_cntr_q <= wd_cntr_d;
                    acc_q     <= acc_d;
                end
            end
        end else if (data_in_width > data_out_width) begin : g_downsize
            localparam int CW = $clog2(K);
            logic [CW-1:0]   rd_cntr_q, rd_cntr_d;
            logic [MAXW-1:0] w_shifted;
            logic            w_last, w_pop_ok, w_unused;
            int              w_sh;

            assign w_unused   = flush_n;
            assign w_last     = (rd_cntr_q == CW'(K - 1));
            assign w_pop_ok   = w_pop & ~w_ram_empty;
            // The RAM word is only retired once its last sub-word is popped.
            assign w_int_pop  = w_pop_ok & w_last;
            assign w_int_push = w_push;
            assign wr_data    = data_in;
            assign full       = w_ram_full;
            assign part_wd    = 1'b0;

            assign w_sh      = (byte_order == 0) ? (K - 1 - int'(rd_cntr_q)) * data_out_width
                                                 : int'(rd_cntr_q) * data_out_width;
            assign w_shifted = rd_data >> w_sh;
            assign data_out  = w_shifted[data_out_width-1:0];

            always_comb begin
                rd_cntr_d = rd_cntr_q;
                if (w_pop_ok) begin
                    rd_cntr_d = w_last ? '0 : rd_cntr_q + CW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_cntr_q <= '0;
                end else begin
                    rd_cntr_q <= rd_cntr_d;
                end
            end
        end else begin : g_equal
            logic w_unused;
            assign w_unused   = flush_n;
            assign w_int_push = w_push;
            assign w_int_pop  = w_pop & ~w_ram_empty;
            assign wr_data    = data_in;
            assign data_out   = rd_data;
            assign full       = w_ram_full;
            assign part_wd    = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_asym_fifoctl_s1_df.sv
`default_nettype none
// ============================================================================
//  Module   : tb_asym_fifoctl_s1_df
//  Purpose  : Directed self-checking bench for asym_fifoctl_s1_df. One
//             upsizing instance (8->32, depth 4, sticky errors) and one
//             downsizing instance (32->8, depth 4, per-cycle errors), each
//             attached to a small behavioural RAM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_asym_fifoctl_s1_df;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- upsize instance ----------------
    logic        u_rst_n = 1'b0, u_push_n = 1'b1, u_flush_n = 1'b1, u_pop_n = 1'b1;
    logic [7:0]  u_din = '0;
    logic [31:0] u_rd_data, u_wr_data, u_dout;
    logic [2:0]  u_ae = '0, u_af = '0, u_cnt;
    logic [1:0]  u_wa, u_ra, u_err;
    logic        u_we_n, u_empty, u_aempty, u_hf, u_afull, u_full, u_rfull, u_part;
    logic [31:0] u_mem [4];
    wire  [7:0]  u_flags = {u_empty, u_aempty, u_hf, u_afull, u_full, u_rfull, u_part, u_we_n};

    asym_fifoctl_s1_df #(.data_in_width(8), .data_out_width(32), .depth(4),
                         .err_mode(0), .byte_order(0)) u_up (
        .clk(clk), .rst_n(u_rst_n), .push_req_n(u_push_n), .flush_n(u_flush_n),
        .pop_req_n(u_pop_n), .data_in(u_din), .rd_data(u_rd_data),
        .ae_level(u_ae), .af_level(u_af), .we_n(u_we_n), .wr_addr(u_wa),
        .rd_addr(u_ra), .wr_data(u_wr_data), .data_out(u_dout), .word_count(u_cnt),
        .empty(u_empty), .almost_empty(u_aempty), .half_full(u_hf),
        .almost_full(u_afull), .full(u_full), .ram_full(u_rfull),
        .part_wd(u_part), .error(u_err));

    always @(posedge clk) if (!u_we_n) u_mem[u_wa] <= u_wr_data;
    assign u_rd_data = u_mem[u_ra];

    // ---------------- downsize instance ----------------
    logic        d_rst_n = 1'b0, d_push_n = 1'b1, d_flush_n = 1'b1, d_pop_n = 1'b1;
    logic [31:0] d_din = '0, d_rd_data, d_wr_data;
    logic [7:0]  d_dout;
    logic [2:0]  d_ae = '0, d_af = '0, d_cnt;
    logic [1:0]  d_wa, d_ra, d_err;
    logic        d_we_n, d_empty, d_aempty, d_hf, d_afull, d_full, d_rfull, d_part;
    logic [31:0] d_mem [4];

    asym_fifoctl_s1_df #(.data_in_width(32), .data_out_width(8), .depth(4),
                         .err_mode(1), .byte_order(0)) u_dn (
        .clk(clk), .rst_n(d_rst_n), .push_req_n(d_push_n), .flush_n(d_flush_n),
        .pop_req_n(d_pop_n), .data_in(d_din), .rd_data(d_rd_data),
        .ae_level(d_ae), .af_level(d_af), .we_n(d_we_n), .wr_addr(d_wa),
        .rd_addr(d_ra), .wr_data(d_wr_data), .data_out(d_dout), .word_count(d_cnt),
        .empty(d_empty), .almost_empty(d_aempty), .half_full(d_hf),
        .almost_full(d_afull), .full(d_full), .ram_full(d_rfull),
        .part_wd(d_part), .error(d_err));

    always @(posedge clk) if (!d_we_n) d_mem[d_wa] <= d_wr_data;
    assign d_rd_data = d_mem[d_ra];

    task automatic u_push(input logic [7:0] v);
        u_push_n = 1'b0;
        u_din    = v;
        tick();
        u_push_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            u_mem[i] = '0;
            d_mem[i] = '0;
        end

        // ---------------- upsize: reset ----------------
        #3;
        check("up_rst_flags", u_flags, 8'b1100_0001);
        check("up_rst_cnt",   u_cnt, 0);
        check("up_rst_err",   u_err, 0);
        @(negedge clk);
        u_rst_n = 1'b1;
        tick();

        // Four pushes pack into one RAM word, one write strobe on the 4th.
        u_push(8'h11);
        check("up_part_after1", u_part, 1);
        u_push(8'h22);
        u_push_n = 1'b0; u_din = 8'h33; #1;
        check("up_we_3rd", u_we_n, 1);
        tick();
        u_din = 8'h44; #1;
        check("up_we_4th",    u_we_n, 0);
        check("up_wdata_4th", u_wr_data, 32'h1122_3344);
        check("up_waddr_4th", u_wa, 0);
        tick();
        u_push_n = 1'b1;
        check("up_cnt_1",  u_cnt, 1);
        check("up_part_0", u_part, 0);
        check("up_dout",   u_dout, 32'h1122_3344);
        check("up_empty0", u_empty, 0);

        // Partial word flushed left-justified.
        u_push(8'hAA);
        u_push(8'hBB);
        check("up_part_pre_flush", u_part, 1);
        u_flush_n = 1'b0; #1;
        check("up_flush_we",    u_we_n, 0);
        check("up_flush_wdata", u_wr_data, 32'hAABB_0000);
        tick();
        u_flush_n = 1'b1;
        check("up_flush_part", u_part, 0);
        check("up_flush_cnt",  u_cnt, 2);

        // Runtime thresholds respond in the same cycle.
        u_ae = 3'd2; #1;
        check("up_ae_lvl2", u_aempty, 1);
        u_ae = 3'd1; #1;
        check("up_ae_lvl1", u_aempty, 0);
        check("up_hf_2",    u_hf, 1);
        check("up_af_lvl0", u_afull, 0);
        u_af = 3'd2; #1;
        check("up_af_lvl2", u_afull, 1);
        u_af = 3'd7; #1;
        check("up_af_sat",  u_afull, 1);
        u_af = 3'd0;

        // Fill the RAM.
        for (int i = 0; i < 8; i++) u_push(8'(i + 1));
        check("up_fill_cnt",   u_cnt, 4);
        check("up_fill_rfull", u_rfull, 1);
        check("up_fill_full",  u_full, 0);
        check("up_fill_af",    u_afull, 1);
        for (int i = 0; i < 3; i++) u_push(8'h50);
        check("up_full_k1", u_full, 1);

        // Word-completing push into a full RAM is dropped and flagged.
        u_push_n = 1'b0; u_din = 8'h5F; #1;
        check("up_ovf_we", u_we_n, 1);
        tick();
        u_push_n = 1'b1;
        check("up_ovf_err",  u_err, 2'b01);
        check("up_ovf_full", u_full, 1);
        check("up_ovf_cnt",  u_cnt, 4);
        tick();
        check("up_ovf_sticky", u_err, 2'b01);

        // Asynchronous reset in the middle of a word.
        u_rst_n = 1'b0; #2;
        check("up_rst2_flags", u_flags, 8'b1100_0001);
        check("up_rst2_err",   u_err, 0);
        @(negedge clk);
        u_rst_n = 1'b1;
        tick();
        u_push(8'h01);
        u_push(8'h02);
        #2;
        u_rst_n = 1'b0; #1;
        check("up_rst3_flags", u_flags, 8'b1100_0001);
        check("up_rst3_cnt",   u_cnt, 0);
        @(negedge clk);
        u_rst_n = 1'b1;
        tick();

        // Pop on empty raises underflow.
        u_pop_n = 1'b0;
        tick();
        u_pop_n = 1'b1;
        check("up_udf_err", u_err, 2'b10);
        check("up_udf_cnt", u_cnt, 0);

        // Packing restarts at sub-word 0.
        u_push(8'hA1);
        u_push(8'hA2);
        u_push(8'hA3);
        u_push_n = 1'b0; u_din = 8'hA4; #1;
        check("up_repack_we",    u_we_n, 0);
        check("up_repack_wdata", u_wr_data, 32'hA1A2_A3A4);
        tick();
        u_push_n = 1'b1;

        // ---------------- downsize ----------------
        check("dn_rst_empty", d_empty, 1);
        check("dn_rst_we",    d_we_n, 1);
        @(negedge clk);
        d_rst_n = 1'b1;
        tick();

        d_push_n = 1'b0; d_din = 32'h0102_0304; #1;
        check("dn_we",    d_we_n, 0);
        check("dn_wdata", d_wr_data, 32'h0102_0304);
        tick();
        d_push_n = 1'b1;
        check("dn_cnt_1", d_cnt, 1);

        d_pop_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("dn_dout", d_dout, 8'(i + 1));
            check("dn_raddr_hold", d_ra, 0);
            tick();
        end
        check("dn_raddr_adv", d_ra, 1);
        check("dn_empty",     d_empty, 1);
        // pop_n still low: pop on an empty RAM.
        tick();
        d_pop_n = 1'b1;
        check("dn_udf",       d_err, 2'b10);
        tick();
        check("dn_udf_clear", d_err, 2'b00);

        for (int i = 0; i < 4; i++) begin
            d_push_n = 1'b0;
            d_din    = 32'hA0A1_A2A3 + 32'(i);
            tick();
        end
        d_push_n = 1'b1;
        check("dn_fill_cnt",  d_cnt, 4);
        check("dn_fill_full", d_full, 1);
        check("dn_fill_dout", d_dout, 8'hA0);

        d_push_n = 1'b0; d_din = 32'hDEAD_BEEF; #1;
        check("dn_ovf_we", d_we_n, 1);
        tick();
        d_push_n = 1'b1;
        check("dn_ovf_err", d_err, 2'b01);
        tick();
        check("dn_ovf_clear", d_err, 2'b00);

        // Push into a full RAM is accepted when the last sub-word pops.
        d_pop_n = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("dn_sub3_dout", d_dout, 8'hA3);
        check("dn_sub3_cnt",  d_cnt, 4);
        d_push_n = 1'b0; d_din = 32'h5566_7788; #1;
        check("dn_pushpop_we", d_we_n, 0);
        tick();
        d_push_n = 1'b1;
        d_pop_n  = 1'b1;
        check("dn_pushpop_cnt", d_cnt, 4);
        check("dn_pushpop_err", d_err, 2'b00);
        check("dn_pushpop_ra",  d_ra, 2);
        check("dn_next_dout",   d_dout, 8'hA0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
